// File: rtl/ec_sched_pkg.sv
// Shared constants for the enable-gated register write scheduler:
// FSM state encodings and the polarity of the register clock-enable.
package ec_sched_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETUP   = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // EC high blocks the register clock (Cdff = C | EC).
  localparam logic EC_HOLD    = 1'b1;
  localparam logic EC_CAPTURE = 1'b0;

endpackage

// File: rtl/ec_sched_rr_pick.sv
// Combinational round-robin picker: lowest-index request at or above ptr,
// wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   win,
  output logic            valid
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Scan from the farthest candidate down so the nearest one wins last.
  always_comb begin
    win   = '0;
    valid = |req;
    sum   = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PW + 1)'(k);
      if (sum >= (PW + 1)'(NREQ)) begin
        sum = sum - (PW + 1)'(NREQ);
      end
      idx = sum[PW-1:0];
      if (req[idx]) begin
        win = idx;
      end
    end
  end

endmodule

// File: rtl/ec_sched.sv
// Write scheduler for one clock-enable-gated register shared by NREQ requesters:
// arbitrates, presents data, opens the clock for one cycle, then acknowledges.
module ec_sched
  import ec_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              C,
  input  logic              nR,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*W-1:0] WD,
  output logic [NREQ-1:0]   GNT,
  output logic [W-1:0]      D,
  output logic              EC,
  output logic              BUSY,
  output logic [7:0]        WCNT
);

  localparam int PW = $clog2(NREQ);

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   win_q, win_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]    data_q, data_d;
  logic            ec_q, ec_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      wcnt_q, wcnt_d;

  logic [PW-1:0]   pick_win;
  logic            pick_valid;
  logic [W-1:0]    wd_slice [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign wd_slice[gi] = WD[gi*W +: W];
  end

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    wcnt_d  = wcnt_q;
    ec_d    = EC_HOLD;
    gnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          win_d   = pick_win;
          data_d  = wd_slice[pick_win];
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // Winner withdrew before the clock opened: drop silently.
        if (!REQ[win_q]) begin
          state_d = ST_IDLE;
        end else begin
          ec_d    = EC_CAPTURE;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        gnt_d   = NREQ'(1) << win_q;
        wcnt_d  = wcnt_q + 8'd1;
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      ec_q    <= EC_HOLD;
      gnt_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      ec_q    <= ec_d;
      gnt_q   <= gnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign GNT  = gnt_q;
  assign D    = data_q;
  assign EC   = ec_q;
  assign BUSY = (state_q != ST_IDLE);
  assign WCNT = wcnt_q;

endmodule

// File: tb/tb_ec_sched.sv
// Directed bench for ec_sched with a behavioural gated-clock register on D/EC.
module tb_ec_sched;

  logic        C = 1'b0;
  logic        nR;
  logic [3:0]  REQ;
  logic [31:0] WD;
  logic [3:0]  GNT;
  logic [7:0]  D;
  logic        EC;
  logic        BUSY;
  logic [7:0]  WCNT;

  int n_assert = 0;
  int n_fail   = 0;

  logic        cdff;
  logic [7:0]  q_reg = 8'h00;
  logic [7:0]  d_prev = 8'h00;
  logic        mon_en = 1'b0;

  ec_sched #(.NREQ(4), .W(8)) dut (
    .C    (C),
    .nR   (nR),
    .REQ  (REQ),
    .WD   (WD),
    .GNT  (GNT),
    .D    (D),
    .EC   (EC),
    .BUSY (BUSY),
    .WCNT (WCNT)
  );

  always #5 C = ~C;

  // External register clocked through the enable gate.
  assign cdff = C | EC;
  always @(posedge cdff) q_reg <= D;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Continuous checks: single grant, and D stable whenever the clock is open.
  always @(negedge C) begin
    if (mon_en && nR === 1'b1) begin
      chk("gnt_onehot", {31'd0, ($countones(GNT) <= 1)}, 32'd1);
      if (EC === 1'b0) chk("d_stable_ec0", {24'd0, D}, {24'd0, d_prev});
    end
    d_prev = D;
  end

  task automatic step();
    @(negedge C);
  endtask

  function automatic logic [7:0] wd_of(input int idx);
    case (idx)
      0: return 8'h11;
      1: return 8'h22;
      2: return 8'hA5;
      default: return 8'h44;
    endcase
  endfunction

  // Entry: IDLE at a negedge with REQ already driven. Exit: back in IDLE.
  task automatic run_write(input int idx, input logic [7:0] cnt);
    logic [7:0] data;
    data = wd_of(idx);
    step();
    chk("setup_busy", {31'd0, BUSY}, 32'd1);
    chk("setup_d",    {24'd0, D},    {24'd0, data});
    chk("setup_ec",   {31'd0, EC},   32'd1);
    chk("setup_gnt",  {28'd0, GNT},  32'd0);
    step();
    chk("write_ec",   {31'd0, EC},   32'd0);
    chk("write_d",    {24'd0, D},    {24'd0, data});
    chk("write_gnt",  {28'd0, GNT},  32'd0);
    step();
    chk("rel_gnt",    {28'd0, GNT},  32'd1 << idx);
    chk("rel_ec",     {31'd0, EC},   32'd1);
    chk("rel_wcnt",   {24'd0, WCNT}, {24'd0, cnt});
    chk("rel_q",      {24'd0, q_reg}, {24'd0, data});
    step();
    chk("idle_busy",  {31'd0, BUSY}, 32'd0);
    chk("idle_gnt",   {28'd0, GNT},  32'd0);
    $display("write req=%0d data=%h gnt=%b wcnt=%0d q=%h", idx, data, 4'b0001 << idx, WCNT, q_reg);
  endtask

  initial begin
    WD  = {8'h44, 8'hA5, 8'h22, 8'h11};
    REQ = 4'b1111;
    nR  = 1'b1;
    #2 nR = 1'b0;
    #1;
    chk("rst_async_ec",   {31'd0, EC},   32'd1);
    chk("rst_async_gnt",  {28'd0, GNT},  32'd0);
    chk("rst_async_d",    {24'd0, D},    32'd0);
    chk("rst_async_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_async_wcnt", {24'd0, WCNT}, 32'd0);
    step();
    step();
    chk("rst_hold_ec",   {31'd0, EC},   32'd1);
    chk("rst_hold_gnt",  {28'd0, GNT},  32'd0);
    chk("rst_hold_wcnt", {24'd0, WCNT}, 32'd0);
    mon_en = 1'b1;

    // Fairness with all requesting: 0,1,2,3,0.
    nR = 1'b1;
    for (int k = 0; k < 5; k++) run_write(k % 4, 8'(k + 1));

    // Single write from requester 2 (ptr=1).
    REQ = 4'b0100;
    run_write(2, 8'd6);
    REQ = 4'b0000;
    step();
    chk("quiet_busy", {31'd0, BUSY}, 32'd0);

    // Abort: ptr=3, requester 1 wins then drops in SETUP.
    REQ = 4'b0010;
    step();
    chk("abort_setup_busy", {31'd0, BUSY}, 32'd1);
    chk("abort_setup_d",    {24'd0, D},    32'h22);
    REQ = 4'b0000;
    step();
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_ec",   {31'd0, EC},   32'd1);
    chk("abort_gnt",  {28'd0, GNT},  32'd0);
    step();
    chk("abort_gnt2", {28'd0, GNT},  32'd0);
    chk("abort_wcnt", {24'd0, WCNT}, 32'd6);
    chk("abort_q",    {24'd0, q_reg}, 32'hA5);
    $display("abort req=1 wcnt=%0d q=%h", WCNT, q_reg);
    // Pointer still 3 after the abort.
    REQ = 4'b1111;
    run_write(3, 8'd7);

    // Reset while in WRITE (ptr=0).
    REQ = 4'b0001;
    step();
    chk("mw_setup_d", {24'd0, D}, 32'h11);
    step();
    chk("mw_write_ec", {31'd0, EC}, 32'd0);
    nR = 1'b0;
    #1;
    chk("mw_rst_ec",   {31'd0, EC},   32'd1);
    chk("mw_rst_gnt",  {28'd0, GNT},  32'd0);
    chk("mw_rst_wcnt", {24'd0, WCNT}, 32'd0);
    chk("mw_rst_busy", {31'd0, BUSY}, 32'd0);
    step();
    step();
    chk("mw_hold_gnt", {28'd0, GNT}, 32'd0);
    chk("mw_hold_ec",  {31'd0, EC},  32'd1);
    $display("midwrite reset wcnt=%0d ec=%b", WCNT, EC);

    // First arbitration after reset goes to requester 0.
    REQ = 4'b1111;
    nR  = 1'b1;
    run_write(0, 8'd1);

    // Run the counter around: 255 more writes bring WCNT to 0.
    for (int k = 0; k < 255; k++) run_write((k + 1) % 4, 8'(k + 2));
    chk("wcnt_wrap", {24'd0, WCNT}, 32'd0);
    REQ = 4'b0000;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
